// File: rtl/i2c_target.sv
// I2C target with a 16 x 8 register file, auto-incrementing pointer and local read port.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample deglitcher after the synchronizers.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned CLK_HZ   = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  if (CLK_HZ == 0) begin : g_clk_hz_check
    $error("CLK_HZ must be nonzero");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic       scl_flt_q, sda_flt_q;
  logic [1:0] scl_cnt_q, sda_cnt_q;

  // Output follows the input only on the third consecutive differing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      if (scl_sync_q[1] == scl_flt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == 2'd2) begin
        scl_flt_q <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 2'd1;
      end
      if (sda_sync_q[1] == sda_flt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == 2'd2) begin
        sda_flt_q <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 2'd1;
      end
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start_c  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_c   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       mack_q, mack_d;
  logic       wr_stb_q, wr_stb_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rd_data_q;
  logic [7:0] regs_q [16];
  logic [7:0] byte_in, rd_byte;

  assign byte_in = {shift_q[6:0], sda_f};
  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    mack_d    = mack_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_f;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        // First falling edge in an ACK state is the 8th (assert), the second is the 9th (release).
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = RDATA;
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = byte_in[3:0];
            state_d = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = byte_in;
            ptr_d     = ptr_q + 4'd1;
            state_d   = WDATA_ACK;
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            mack_d   = 1'b0;
            state_d  = RDATA_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], shift_q[7]};
            sda_oe_d  = ~shift_q[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d  = ptr_q + 4'd1;
              mack_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && mack_q) begin
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            mack_d    = 1'b0;
            state_d   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= regs_q[rd_addr];
      if (wr_stb_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master tasks, register-file model, write-event log.
// Glitch scenario is compiled in only with I2C_TARGET_GLITCH_FILTER_EN.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       busy, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, rd_data;
  wire        sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h48), .CLK_HZ(50_000_000)) dut (
    .clk(clk), .reset(rst_n), .scl(m_scl), .sda(sda_bus), .busy(busy),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  model_regs [16];
  logic [7:0]  wbuf [16];
  logic [7:0]  rbuf [16];
  logic [11:0] wr_log [$];
  int          low_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_stb) wr_log.push_back({wr_addr, wr_data});
    if (sda_bus === 1'b0 && !m_sda_low) low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b0;     qwait();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i];
      if (glitch && i == 4) begin
        @(negedge clk); m_scl = 1'b1; @(negedge clk); m_scl = 1'b0;
      end
      qwait(); m_scl = 1'b1; qwait(); qwait(); m_scl = 1'b0; qwait();
    end
    m_sda_low = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    ack = (sda_bus === 1'b0);
    qwait(); m_scl = 1'b0; qwait();
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      qwait(); m_scl = 1'b1; qwait();
      b[i] = (sda_bus !== 1'b0);
      qwait(); m_scl = 1'b0;
    end
    qwait(); m_sda_low = mack; qwait();
    m_scl = 1'b1; qwait(); qwait(); m_scl = 1'b0; qwait();
    m_sda_low = 1'b0;
  endtask

  task automatic xact_write(input logic [7:0] addr_byte, input logic [3:0] p, input int n,
                            output int acks);
    bit a;
    acks = 0;
    bus_start();
    write_byte(addr_byte, 1'b0, a); acks += int'(a);
    write_byte({4'h0, p}, 1'b0, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], 1'b0, a); acks += int'(a);
    end
    bus_stop();
  endtask

  task automatic xact_read(input logic [3:0] p, input int n, output int acks, output logic busy_end);
    bit a;
    acks = 0;
    bus_start();
    write_byte(8'h90, 1'b0, a); acks += int'(a);
    write_byte({4'h0, p}, 1'b0, a); acks += int'(a);
    bus_start();
    write_byte(8'h91, 1'b0, a); acks += int'(a);
    for (int i = 0; i < n; i++) read_byte(i != n - 1, rbuf[i]);
    busy_end = busy;
    bus_stop();
  endtask

  task automatic model_write(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) model_regs[4'(p + i)] = wbuf[i];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_stb !== 1'b0)  begin errors++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end
    checks++; if (wr_addr !== 4'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    rst_n = 1'b1;
    qwait();
  endtask

  task automatic test_write();
    int acks, base;
    base = wr_log.size();
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    xact_write(8'h90, 4'h3, 2, acks);
    model_write(4'h3, 2);
    checks++; if (acks != 4) begin errors++; $display("FAIL write_acks got %0d want 4", acks); end
    checks++; if (wr_log.size() != base + 2) begin errors++; $display("FAIL write_stb_count got %0d want 2", wr_log.size() - base); end
    else begin
      checks++; if (wr_log[base] !== 12'h3A5) begin errors++; $display("FAIL write_ev0 got %h want 3a5", wr_log[base]); end
      checks++; if (wr_log[base+1] !== 12'h45A) begin errors++; $display("FAIL write_ev1 got %h want 45a", wr_log[base+1]); end
    end
    rd_addr = 4'h4;
    repeat (2) @(negedge clk);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL write_rd_data got %h want 5a", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_read();
    int acks;
    logic b_end;
    xact_read(4'h3, 2, acks, b_end);
    checks++; if (acks != 3) begin errors++; $display("FAIL read_acks got %0d want 3", acks); end
    checks++; if (rbuf[0] !== 8'hA5) begin errors++; $display("FAIL read_byte0 got %h want a5", rbuf[0]); end
    checks++; if (rbuf[1] !== 8'h5A) begin errors++; $display("FAIL read_byte1 got %h want 5a", rbuf[1]); end
    checks++; if (b_end !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack got %b want 0", b_end); end
  endtask

  task automatic test_mismatch();
    int acks, base, l0, b0;
    base = wr_log.size(); l0 = low_cnt; b0 = busy_cnt;
    xact_write(8'h92, 4'h0, 0, acks);
    checks++; if (acks != 0) begin errors++; $display("FAIL mismatch_acks got %0d want 0", acks); end
    checks++; if (low_cnt != l0) begin errors++; $display("FAIL mismatch_sda_low got %0d clks want 0", low_cnt - l0); end
    checks++; if (busy_cnt != b0) begin errors++; $display("FAIL mismatch_busy got %0d clks want 0", busy_cnt - b0); end
    checks++; if (wr_log.size() != base) begin errors++; $display("FAIL mismatch_wr_stb got %0d want 0", wr_log.size() - base); end
  endtask

  task automatic test_wrap();
    int acks, base;
    base = wr_log.size();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    xact_write(8'h90, 4'hF, 3, acks);
    model_write(4'hF, 3);
    checks++; if (acks != 5) begin errors++; $display("FAIL wrap_acks got %0d want 5", acks); end
    checks++; if (wr_log.size() != base + 3) begin errors++; $display("FAIL wrap_count got %0d want 3", wr_log.size() - base); end
    else begin
      checks++; if (wr_log[base]   !== 12'hF11) begin errors++; $display("FAIL wrap_ev0 got %h want f11", wr_log[base]); end
      checks++; if (wr_log[base+1] !== 12'h022) begin errors++; $display("FAIL wrap_ev1 got %h want 022", wr_log[base+1]); end
      checks++; if (wr_log[base+2] !== 12'h133) begin errors++; $display("FAIL wrap_ev2 got %h want 133", wr_log[base+2]); end
    end
  endtask

  task automatic test_random();
    int acks, base, n;
    logic [3:0] p;
    logic b_end;
    for (int it = 0; it < 6; it++) begin
      p = 4'($urandom_range(0, 15));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      base = wr_log.size();
      xact_write(8'h90, p, n, acks);
      model_write(p, n);
      checks++; if (acks != n + 2) begin errors++; $display("FAIL rnd_write_acks got %0d want %0d", acks, n + 2); end
      checks++; if (wr_log.size() != base + n) begin errors++; $display("FAIL rnd_write_count got %0d want %0d", wr_log.size() - base, n); end
      else for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_log[base+i] !== {4'(p + i), wbuf[i]}) begin
          errors++; $display("FAIL rnd_write_ev got %h want %h", wr_log[base+i], {4'(p + i), wbuf[i]});
        end
      end
      p = 4'($urandom_range(0, 15));
      n = int'($urandom_range(1, 3));
      xact_read(p, n, acks, b_end);
      checks++; if (acks != 3) begin errors++; $display("FAIL rnd_read_acks got %0d want 3", acks); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rbuf[i] !== model_regs[4'(p + i)]) begin
          errors++; $display("FAIL rnd_read_byte got %h want %h", rbuf[i], model_regs[4'(p + i)]);
        end
      end
      rd_addr = 4'($urandom_range(0, 15));
      repeat (2) @(negedge clk);
      checks++; if (rd_data !== model_regs[rd_addr]) begin errors++; $display("FAIL rnd_local_rd got %h want %h", rd_data, model_regs[rd_addr]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acks, base;
    bit a;
    wbuf[0] = 8'h00;
    xact_write(8'h90, 4'h7, 1, acks);
    model_write(4'h7, 1);
    bus_start();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h07, 1'b0, a);
    bus_start();
    write_byte(8'h91, 1'b0, a);
    m_sda_low = 1'b0;
    for (int i = 7; i > 4; i--) begin
      qwait(); m_scl = 1'b1; qwait(); qwait(); m_scl = 1'b0;
    end
    qwait(); m_scl = 1'b1; qwait();
    checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rst_mid_drive got %b want 0", sda_bus); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rst_mid_release got %b want 1", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    m_scl = 1'b0; qwait();
    rst_n = 1'b1; qwait();
    bus_stop();
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    base = wr_log.size();
    wbuf[0] = 8'h3C;
    xact_write(8'h90, 4'h2, 1, acks);
    model_write(4'h2, 1);
    checks++; if (acks != 3) begin errors++; $display("FAIL rst_after_acks got %0d want 3", acks); end
    checks++; if (wr_log.size() != base + 1 || wr_log[wr_log.size()-1] !== 12'h23C) begin
      errors++; $display("FAIL rst_after_ev got count %0d want 1 (last 23c)", wr_log.size() - base);
    end
    rd_addr = 4'h4;
    repeat (2) @(negedge clk);
    checks++; if (rd_data !== model_regs[4]) begin errors++; $display("FAIL rst_regs_cleared got %h want %h", rd_data, model_regs[4]); end
    rd_addr = 4'h2;
    repeat (2) @(negedge clk);
    checks++; if (rd_data !== model_regs[2]) begin errors++; $display("FAIL rst_after_rd got %h want %h", rd_data, model_regs[2]); end
  endtask

  task automatic test_glitch();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    bit a;
    int acks, base;
    m_sda_low = 1'b1; repeat (2) @(negedge clk); m_sda_low = 1'b0;
    qwait();
    m_scl = 1'b0; qwait();
    write_byte(8'h90, 1'b0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL glitch_sda_start got ack %b want 0", a); end
    bus_stop();
    m_scl = 1'b0; @(negedge clk); m_scl = 1'b1;
    qwait();
    base = wr_log.size();
    acks = 0;
    bus_start();
    write_byte(8'h90, 1'b1, a); acks += int'(a);
    write_byte(8'h05, 1'b0, a); acks += int'(a);
    write_byte(8'h6E, 1'b0, a); acks += int'(a);
    bus_stop();
    model_regs[5] = 8'h6E;
    checks++; if (acks != 3) begin errors++; $display("FAIL glitch_scl_acks got %0d want 3", acks); end
    checks++; if (wr_log.size() != base + 1 || wr_log[wr_log.size()-1] !== 12'h56E) begin
      errors++; $display("FAIL glitch_scl_ev got count %0d want 1 (last 56e)", wr_log.size() - base);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_random();
    test_reset_mid_read();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
